axi_slave_mem_lat: RTL and testbench

- Parametrised AXI4 full slave memory. Self-contained byte-addressable RAM with independent, concurrent read and write channels.
- Supports FIXED, INCR and WRAP bursts with narrow (AxSIZE) addressing, a configurable read latency, and DECERR on out-of-range accesses.
- Next-generation simulation/FPGA memory behind the core's AXI master. Replaces the shared-channel, DPI-backed slave.

---
 rtl/axi_slave_mem_lat.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_axi_slave_mem_lat.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem_lat.sv
// AXI4 slave backed by an internal byte-addressable RAM.
// Independent read/write FSMs, FIXED/INCR/WRAP bursts, narrow beats, programmable read latency.
module axi_slave_mem_lat #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h8000_0000),
  parameter int RD_LATENCY = 1
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESET,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [2:0]              S_AXI_AWSIZE,
  input  logic [1:0]              S_AXI_AWBURST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]              S_AXI_BRESP,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]              S_AXI_ARLEN,
  input  logic [2:0]              S_AXI_ARSIZE,
  input  logic [1:0]              S_AXI_ARBURST,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_RID,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RLAST
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    if (s > 3'(BYTE_SH)) return 3'(BYTE_SH);
    return s;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    inc  = addr + (ADDR_WIDTH'(1) << size);
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    if (burst == 2'b00) return addr;
    // Non power-of-two WRAP lengths degrade to INCR.
    if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      return (addr & ~mask) | (inc & mask);
    return inc;
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    if (addr < BASE_ADDR) return 1'b0;
    return ((addr - BASE_ADDR) >> BYTE_SH) < ADDR_WIDTH'(MEM_DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> BYTE_SH);
  endfunction

  logic [1:0]            wstate_q, wstate_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d;
  logic [8:0]            wbeat_q, wbeat_d;
  logic                  werr_q, werr_d;
  logic                  mem_we, w_ok;
  logic [IDX_W-1:0]      mem_widx;

  logic [1:0]            rstate_q, rstate_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            rlen_q, rlen_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;
  logic [8:0]            rbeat_q, rbeat_d;
  logic [3:0]            rlat_q, rlat_d;
  logic [ADDR_WIDTH-1:0] rfetch;
  logic                  rfetch_ok;
  logic [DATA_WIDTH-1:0] rfetch_data;

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    w_ok      = in_range(waddr_q);
    mem_we    = 1'b0;
    mem_widx  = word_idx(waddr_q);
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (S_AXI_AWVALID && awready_q) begin
          bid_d     = S_AXI_AWID;
          waddr_d   = S_AXI_AWADDR;
          wlen_d    = S_AXI_AWLEN;
          wsize_d   = clamp_size(S_AXI_AWSIZE);
          wburst_d  = S_AXI_AWBURST;
          wbeat_d   = 9'd0;
          werr_d    = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wstate_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID && wready_q) begin
          mem_we  = w_ok;
          waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
          wbeat_d = wbeat_q + 9'd1;
          werr_d  = werr_q | ~w_ok;
          if (S_AXI_WLAST) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            wstate_d = W_RESP;
            if (werr_q || !w_ok)                             bresp_d = 2'b11;
            else if (wbeat_q + 9'd1 != {1'b0, wlen_q} + 9'd1) bresp_d = 2'b10;
            else                                             bresp_d = 2'b00;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Fetch address: the latched start while waiting, the following beat while streaming.
  always_comb begin
    rfetch      = (rstate_q == R_DATA) ? next_addr(raddr_q, rlen_q, rsize_q, rburst_q) : raddr_q;
    rfetch_ok   = in_range(rfetch);
    rfetch_data = rfetch_ok ? mem[word_idx(rfetch)] : '0;
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rbeat_d   = rbeat_q;
    rlat_d    = rlat_q;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (S_AXI_ARVALID && arready_q) begin
          rid_d     = S_AXI_ARID;
          raddr_d   = S_AXI_ARADDR;
          rlen_d    = S_AXI_ARLEN;
          rsize_d   = clamp_size(S_AXI_ARSIZE);
          rburst_d  = S_AXI_ARBURST;
          rlat_d    = 4'(RD_LATENCY - 1);
          arready_d = 1'b0;
          rstate_d  = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rlat_q == 4'd0) begin
          rvalid_d = 1'b1;
          rdata_d  = rfetch_data;
          rresp_d  = rfetch_ok ? 2'b00 : 2'b11;
          rlast_d  = (rlen_q == 8'd0);
          rbeat_d  = 9'd0;
          rstate_d = R_DATA;
        end else begin
          rlat_d = rlat_q - 4'd1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY && rvalid_q) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            rstate_d  = R_IDLE;
          end else begin
            raddr_d = rfetch;
            rbeat_d = rbeat_q + 9'd1;
            rlast_d = (rbeat_q + 9'd1 == {1'b0, rlen_q});
            rdata_d = rfetch_data;
            rresp_d = rfetch_ok ? 2'b00 : 2'b11;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= 8'd0;
      wsize_q   <= 3'd0;
      wburst_q  <= 2'b00;
      wbeat_q   <= 9'd0;
      werr_q    <= 1'b0;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      rid_q     <= '0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      rlen_q    <= 8'd0;
      rsize_q   <= 3'd0;
      rburst_q  <= 2'b00;
      rbeat_q   <= 9'd0;
      rlat_q    <= 4'd0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rbeat_q   <= rbeat_d;
      rlat_q    <= rlat_d;
    end
  end

  // Storage is never reset; a read in the same cycle as a write sees the old word.
  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_AXI_WSTRB[b]) mem[mem_widx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_slave_mem_lat.sv
// Directed bench for axi_slave_mem_lat: one instance at read latency 1, one at latency 5
// sharing the write channel so both memories hold the same image.
module tb_axi_slave_mem_lat;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic [3:0]  awid = '0, arid = '0;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic [63:0] wdata = '0;
  logic        arvalid = 1'b0, rready = 1'b0, arvalid2 = 1'b0, rready2 = 1'b0;
  logic        sel = 1'b0;

  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata;
  logic        b_awready, b_wready, b_bvalid, arready2, rvalid2, rlast2;
  logic [3:0]  b_bid, rid2;
  logic [1:0]  b_bresp, rresp2;
  logic [63:0] rdata2;

  logic        m_arready, m_rvalid, m_rlast;
  logic [3:0]  m_rid;
  logic [1:0]  m_rresp;
  logic [63:0] m_rdata;

  int total = 0;
  int bad = 0;
  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [63:0] er_data [16];
  logic [1:0]  er_resp [16];

  axi_slave_mem_lat dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr),
    .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WLAST(wlast), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BID(bid),
    .S_AXI_BRESP(bresp), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARID(arid),
    .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast));

  axi_slave_mem_lat #(.RD_LATENCY(5)) dut5 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(b_awready), .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr),
    .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(b_wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WLAST(wlast), .S_AXI_BVALID(b_bvalid), .S_AXI_BREADY(bready), .S_AXI_BID(b_bid),
    .S_AXI_BRESP(b_bresp), .S_AXI_ARVALID(arvalid2), .S_AXI_ARREADY(arready2), .S_AXI_ARID(arid),
    .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
    .S_AXI_RVALID(rvalid2), .S_AXI_RREADY(rready2), .S_AXI_RID(rid2), .S_AXI_RDATA(rdata2),
    .S_AXI_RRESP(rresp2), .S_AXI_RLAST(rlast2));

  assign m_arready = sel ? arready2 : arready;
  assign m_rvalid  = sel ? rvalid2  : rvalid;
  assign m_rlast   = sel ? rlast2   : rlast;
  assign m_rid     = sel ? rid2     : rid;
  assign m_rresp   = sel ? rresp2   : rresp;
  assign m_rdata   = sel ? rdata2   : rdata;

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                    input logic [1:0] bu, input logic [3:0] id, input int nb,
                    input logic [1:0] exp_resp, input string tag);
    bit hs;
    int n;
    awaddr = a; awlen = len; awsize = sz; awburst = bu; awid = id; awvalid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = awready && b_awready;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    chk({tag, "_aw_hs"}, 64'(hs), 64'd1);
    for (int b = 0; b < nb; b++) begin
      wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = (b == nb - 1);
      hs = 1'b0;
      for (int i = 0; i < 50 && !hs; i++) begin
        hs = wready && b_wready;
        @(posedge clk); #1;
      end
      if (!hs) chk({tag, "_w_hs"}, 64'(hs), 64'd1);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, "_bvalid"}, 64'(bvalid), 64'd1);
    chk({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
    chk({tag, "_bresp_l5"}, 64'(b_bresp), 64'(exp_resp));
    chk({tag, "_bid"}, 64'(bid), 64'(id));
    chk({tag, "_bid_l5"}, 64'(b_bid), 64'(id));
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic rd(input bit s, input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                    input logic [1:0] bu, input logic [3:0] id, input int lat,
                    input int stall_beat, input string tag);
    bit hs;
    int n;
    sel = s; araddr = a; arlen = len; arsize = sz; arburst = bu; arid = id;
    arvalid = !s; arvalid2 = s;
    hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = m_arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0; arvalid2 = 1'b0;
    chk({tag, "_ar_hs"}, 64'(hs), 64'd1);
    n = 0;
    while (!m_rvalid && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!m_rvalid && n < 40) begin @(posedge clk); #1; n++; end
      if (b == stall_beat) begin
        repeat (3) begin
          @(posedge clk); #1;
          chk($sformatf("%s_hold_v%0d", tag, b), 64'(m_rvalid), 64'd1);
          chk($sformatf("%s_hold_d%0d", tag, b), m_rdata, er_data[b]);
          chk($sformatf("%s_hold_l%0d", tag, b), 64'(m_rlast), 64'(b == int'(len)));
        end
      end
      chk($sformatf("%s_data%0d", tag, b), m_rdata, er_data[b]);
      chk($sformatf("%s_resp%0d", tag, b), 64'(m_rresp), 64'(er_resp[b]));
      chk($sformatf("%s_last%0d", tag, b), 64'(m_rlast), 64'(b == int'(len)));
      chk($sformatf("%s_rid%0d", tag, b), 64'(m_rid), 64'(id));
      if (s) rready2 = 1'b1; else rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0; rready2 = 1'b0;
    end
    chk({tag, "_rvalid_end"}, 64'(m_rvalid), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ws[i] = 8'hFF; wd[i] = '0; er_data[i] = '0; er_resp[i] = 2'b00;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_awready", 64'(awready), 64'd1);
    chk("post_rst_arready", 64'(arready), 64'd1);

    // Plain INCR write then readback.
    wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
    wr(32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'h5, 4, 2'b00, "incr_wr");
    er_data[0] = 64'h11; er_data[1] = 64'h22; er_data[2] = 64'h33; er_data[3] = 64'h44;
    rd(1'b0, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'h6, 1, -1, "incr_rd");

    // Narrow single-byte write into lane 2 of word 0.
    wd[0] = 64'h0000_0000_00AB_0000; ws[0] = 8'h04;
    wr(32'h8000_0002, 8'd0, 3'd0, 2'b01, 4'h2, 1, 2'b00, "narrow_wr");
    ws[0] = 8'hFF;
    er_data[0] = 64'h0000_0000_00AB_0011;
    rd(1'b0, 32'h8000_0000, 8'd0, 3'd3, 2'b01, 4'h1, 1, -1, "narrow_rd");

    // WRAP from 0x10 visits words 2,3,0,1.
    er_data[0] = 64'h33; er_data[1] = 64'h44; er_data[2] = 64'h00AB_0011; er_data[3] = 64'h22;
    rd(1'b0, 32'h8000_0010, 8'd3, 3'd3, 2'b10, 4'h3, 1, -1, "wrap_rd");

    // FIXED read repeats the same word.
    er_data[0] = 64'h22; er_data[1] = 64'h22;
    rd(1'b0, 32'h8000_0008, 8'd1, 3'd3, 2'b00, 4'h4, 1, -1, "fixed_rd");

    // Read straddling the bottom of the window.
    er_data[0] = 64'h0; er_resp[0] = 2'b11; er_data[1] = 64'h00AB_0011; er_resp[1] = 2'b00;
    rd(1'b0, 32'h7FFF_FFF8, 8'd1, 3'd3, 2'b01, 4'h7, 1, -1, "oob_rd");
    er_resp[0] = 2'b00;

    // Write one word past the top must be rejected and must not alias word 0.
    wd[0] = 64'hDEAD_BEEF_CAFE_F00D;
    wr(32'h8000_2000, 8'd0, 3'd3, 2'b01, 4'h8, 1, 2'b11, "oob_wr");
    er_data[0] = 64'h00AB_0011;
    rd(1'b0, 32'h8000_0000, 8'd0, 3'd3, 2'b01, 4'h9, 1, -1, "oob_wr_chk");

    // Early WLAST gives SLVERR.
    wd[0] = 64'h55;
    wr(32'h8000_0020, 8'd1, 3'd3, 2'b01, 4'hA, 1, 2'b10, "short_wr");

    // Latency-5 instance with a 3-cycle stall on the last beat.
    er_data[0] = 64'h00AB_0011; er_data[1] = 64'h22; er_data[2] = 64'h33;
    rd(1'b1, 32'h8000_0000, 8'd2, 3'd3, 2'b01, 4'hB, 5, 2, "lat5_rd");

    // Fill words 8..15, then write 16..23 while reading 8..15.
    for (int i = 0; i < 8; i++) wd[i] = 64'h100 + 64'(i);
    wr(32'h8000_0040, 8'd7, 3'd3, 2'b01, 4'hC, 8, 2'b00, "fill_wr");
    for (int i = 0; i < 8; i++) begin
      wd[i] = 64'h200 + 64'(i);
      er_data[i] = 64'h100 + 64'(i);
    end
    fork
      wr(32'h8000_0080, 8'd7, 3'd3, 2'b01, 4'hD, 8, 2'b00, "conc_wr");
      rd(1'b0, 32'h8000_0040, 8'd7, 3'd3, 2'b01, 4'hE, 1, -1, "conc_rd");
    join

    // Abort a read burst with reset.
    sel = 1'b0; araddr = 32'h8000_0080; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01; arid = 4'h1;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
    chk("mid_rst_rdata", rdata, 64'd0);
    chk("mid_rst_rlast", 64'(rlast), 64'd0);
    chk("mid_rst_arready", 64'(arready), 64'd0);
    rready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_arready", 64'(arready), 64'd1);
    chk("after_rst_awready", 64'(awready), 64'd1);
    chk("after_rst_rvalid", 64'(rvalid), 64'd0);
    chk("after_rst_bvalid", 64'(bvalid), 64'd0);
    er_data[0] = 64'h200; er_data[1] = 64'h201;
    rd(1'b0, 32'h8000_0080, 8'd1, 3'd3, 2'b01, 4'h2, 1, -1, "post_rst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
